// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm ringer block.
// Holds the 2-bit FSM state encoding and the width helper used to size the
// second counters so both the snooze and ring-timeout limits fit.
package alarm_pkg;

    // FSM state encoding
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRinging = 2'd1;
    localparam logic [1:0] StSnooze  = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    // Bits needed to hold any value 0..max(a, b).
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/beep_gen.sv
// Buzzer square-wave generator.
// Ports:
//   clk_i    - system clock
//   rst_ni   - synchronous active-low reset
//   en_i     - run request; counter and output clear while low
//   buzzer_o - registered beep drive, BEEP_HALF cycles high then low, repeating
// The output starts high on the first enabled cycle.
module beep_gen #(
    parameter int unsigned BEEP_HALF = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic buzzer_o
);

    localparam int unsigned CW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [CW-1:0] CntLast = CW'(BEEP_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          buzzer_q, buzzer_d;
    logic          run_q, run_d;

    always_comb begin
        cnt_d    = cnt_q;
        buzzer_d = buzzer_q;
        run_d    = run_q;
        if (!en_i) begin
            cnt_d    = '0;
            buzzer_d = 1'b0;
            run_d    = 1'b0;
        end else if (!run_q) begin
            // First enabled cycle: start the high half-period.
            cnt_d    = '0;
            buzzer_d = 1'b1;
            run_d    = 1'b1;
        end else if (cnt_q == CntLast) begin
            cnt_d    = '0;
            buzzer_d = ~buzzer_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            buzzer_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            buzzer_q <= buzzer_d;
            run_q    <= run_d;
        end
    end

    assign buzzer_o = buzzer_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns the upstream isItOn level into ringing behaviour with
// bounded snooze, stop/acknowledge and an auto-timeout.
// Ports:
//   clk          - system clock
//   reset        - synchronous active-low reset
//   isItOn       - alarm-active level from the detection stage
//   sec_tick     - one-cycle pulse per second
//   snooze_btn   - debounced one-cycle pulse
//   stop_btn     - debounced one-cycle pulse
//   buzzer       - registered beep drive (only while ringing)
//   ringing      - high in RINGING
//   snoozing     - high in SNOOZE
//   missed       - sticky: last alarm ended by timeout
//   snooze_count - snoozes used in the current alarm event
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZES      = 3,
    parameter int unsigned BEEP_HALF        = 12_500_000,
    // MAX_SNOOZES=0 would give a zero-width count; keep at least one bit.
    localparam int unsigned SCW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           isItOn,
    input  logic           sec_tick,
    input  logic           snooze_btn,
    input  logic           stop_btn,
    output logic           buzzer,
    output logic           ringing,
    output logic           snoozing,
    output logic           missed,
    output logic [SCW-1:0] snooze_count
);

    localparam int unsigned TW = timer_width(SNOOZE_SEC, RING_TIMEOUT_SEC);
    localparam logic [TW-1:0]  RingLast  = TW'(RING_TIMEOUT_SEC - 1);
    localparam logic [TW-1:0]  SnoozeLd  = TW'(SNOOZE_SEC);
    localparam logic [SCW-1:0] SnoozeMax = SCW'(MAX_SNOOZES);

    logic [1:0]     state_q, state_d;
    logic           ison_q;
    logic [TW-1:0]  ring_q, ring_d;
    logic [TW-1:0]  snz_q, snz_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic           missed_q, missed_d;
    logic           ringing_q, snoozing_q;
    logic           trigger;

    // Rising edge; ison_q clears on reset so a level already high at release triggers.
    assign trigger = isItOn & ~ison_q;

    always_comb begin
        state_d  = state_q;
        ring_d   = ring_q;
        snz_d    = snz_q;
        cnt_d    = cnt_q;
        missed_d = missed_q;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d  = StRinging;
                    ring_d   = '0;
                    cnt_d    = '0;
                    missed_d = 1'b0;
                end
            end
            StRinging: begin
                if (!isItOn) begin
                    state_d = StIdle;
                end else if (stop_btn) begin
                    state_d = StDone;
                end else if (sec_tick && (ring_q == RingLast)) begin
                    state_d  = StDone;
                    missed_d = 1'b1;
                end else if (snooze_btn && (cnt_q < SnoozeMax)) begin
                    state_d = StSnooze;
                    cnt_d   = cnt_q + SCW'(1);
                    snz_d   = SnoozeLd;
                end else if (sec_tick) begin
                    ring_d = ring_q + TW'(1);
                end
            end
            StSnooze: begin
                if (!isItOn) begin
                    state_d = StIdle;
                end else if (stop_btn) begin
                    state_d = StDone;
                end else if (sec_tick) begin
                    if (snz_q == TW'(1)) begin
                        state_d = StRinging;
                        ring_d  = '0;
                        snz_d   = '0;
                    end else begin
                        snz_d = snz_q - TW'(1);
                    end
                end
            end
            default: begin
                // StDone: isItOn stays high from upstream feedback; wait for it to drop.
                if (!isItOn) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            ison_q     <= 1'b0;
            ring_q     <= '0;
            snz_q      <= '0;
            cnt_q      <= '0;
            missed_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ison_q     <= isItOn;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            cnt_q      <= cnt_d;
            missed_q   <= missed_d;
            ringing_q  <= (state_d == StRinging);
            snoozing_q <= (state_d == StSnooze);
        end
    end

    beep_gen #(
        .BEEP_HALF(BEEP_HALF)
    ) u_beep_gen (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (state_d == StRinging),
        .buzzer_o(buzzer)
    );

    assign ringing      = ringing_q;
    assign snoozing     = snoozing_q;
    assign missed       = missed_q;
    assign snooze_count = cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

    logic       clk = 1'b0;
    logic       reset;
    logic       isItOn;
    logic       sec_tick;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic       missed;
    logic [1:0] snooze_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alarm_ringer #(
        .SNOOZE_SEC      (3),
        .RING_TIMEOUT_SEC(5),
        .MAX_SNOOZES     (2),
        .BEEP_HALF       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .isItOn      (isItOn),
        .sec_tick    (sec_tick),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .missed      (missed),
        .snooze_count(snooze_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic snooze();
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
    endtask

    logic [11:0] pat;
    logic        any_ring;

    initial begin
        reset      = 1'b0;
        isItOn     = 1'b0;
        sec_tick   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        step();
        step();
        check("rst_ringing", int'(ringing), 0);
        check("rst_snoozing", int'(snoozing), 0);
        check("rst_buzzer", int'(buzzer), 0);
        check("rst_missed", int'(missed), 0);
        check("rst_count", int'(snooze_count), 0);
        reset = 1'b1;
        step();

        // 1: ring, beep pattern, timeout
        isItOn = 1'b1;
        step();
        check("t1_ringing", int'(ringing), 1);
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            pat[11-i] = buzzer;
            if (i != 11) step();
        end
        check("t1_beep_pattern", int'(pat), int'(12'b1111_0000_1111));
        for (int i = 0; i < 4; i++) tick();
        check("t1_ring_4ticks", int'(ringing), 1);
        tick();
        check("t1_timeout_ringing", int'(ringing), 0);
        check("t1_timeout_missed", int'(missed), 1);
        check("t1_timeout_buzzer", int'(buzzer), 0);
        isItOn = 1'b0;
        step();
        check("t1_idle_missed_sticky", int'(missed), 1);
        step();

        // 2: snooze twice then limit
        isItOn = 1'b1;
        step();
        check("t2_ringing", int'(ringing), 1);
        check("t2_missed_cleared", int'(missed), 0);
        snooze();
        check("t2_snoozing", int'(snoozing), 1);
        check("t2_ringing_off", int'(ringing), 0);
        check("t2_count1", int'(snooze_count), 1);
        tick();
        tick();
        check("t2_still_snoozing", int'(snoozing), 1);
        tick();
        check("t2_resume_ringing", int'(ringing), 1);
        check("t2_resume_buzzer", int'(buzzer), 1);
        snooze();
        check("t2_count2", int'(snooze_count), 2);
        for (int i = 0; i < 3; i++) tick();
        check("t2_resume2", int'(ringing), 1);
        snooze();
        check("t2_limit_ringing", int'(ringing), 1);
        check("t2_limit_snoozing", int'(snoozing), 0);
        check("t2_limit_count", int'(snooze_count), 2);

        // 3: stop beats snooze, no re-ring while held
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        check("t3_ringing", int'(ringing), 0);
        check("t3_snoozing", int'(snoozing), 0);
        check("t3_count", int'(snooze_count), 2);
        check("t3_missed", int'(missed), 0);
        any_ring = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            any_ring = any_ring | ringing | buzzer;
        end
        check("t3_no_rering", int'(any_ring), 0);
        isItOn = 1'b0;
        step();
        step();

        // 4: abort from snooze, fresh event clears count
        isItOn = 1'b1;
        step();
        check("t4_ringing", int'(ringing), 1);
        check("t4_count0", int'(snooze_count), 0);
        snooze();
        check("t4_snoozing", int'(snoozing), 1);
        isItOn = 1'b0;
        step();
        check("t4_abort_snoozing", int'(snoozing), 0);
        check("t4_abort_ringing", int'(ringing), 0);
        check("t4_abort_buzzer", int'(buzzer), 0);
        isItOn = 1'b1;
        step();
        check("t4_rering", int'(ringing), 1);
        check("t4_count_cleared", int'(snooze_count), 0);

        // 5: reset during ringing with buzzer high
        check("t5_buzzer_before", int'(buzzer), 1);
        reset = 1'b0;
        step();
        check("t5_rst_ringing", int'(ringing), 0);
        check("t5_rst_buzzer", int'(buzzer), 0);
        check("t5_rst_missed", int'(missed), 0);
        reset = 1'b1;
        step();
        check("t5_release_ringing", int'(ringing), 1);
        check("t5_release_buzzer", int'(buzzer), 1);

        // 6: tick on the snooze entry cycle is ignored
        sec_tick   = 1'b1;
        snooze_btn = 1'b1;
        step();
        sec_tick   = 1'b0;
        snooze_btn = 1'b0;
        check("t6_snoozing", int'(snoozing), 1);
        check("t6_count", int'(snooze_count), 1);
        tick();
        tick();
        check("t6_two_ticks", int'(snoozing), 1);
        tick();
        check("t6_resume", int'(ringing), 1);
        check("t6_resume_snoozing", int'(snoozing), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
